// File: rtl/slot_reel_engine.sv
// Reel datapath behind the slot-machine control FSM: spins three reels at independent
// rates, freezes them one at a time after STOP, then evaluates win/pair flags.
module slot_reel_engine #(
  parameter int NUM_SYMBOLS = 10,
  parameter int SYM_W       = 4,
  parameter int DIV0        = 1,
  parameter int DIV1        = 2,
  parameter int DIV2        = 3,
  parameter int STOP_GAP    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       state,
  output logic [SYM_W-1:0] reel0,
  output logic [SYM_W-1:0] reel1,
  output logic [SYM_W-1:0] reel2,
  output logic             spin_active,
  output logic             result_valid,
  output logic             win_flag,
  output logic             pair_flag
);

  // state  | meaning
  // IDLE   | waiting for RUN; reels hold last values
  // SPIN   | all three reels free-running
  // SETTLE | reel0 frozen; reel1 then reel2 freeze every STOP_GAP edges
  // EVAL   | one cycle: register win/pair flags from frozen reels
  // HOLD   | result displayed until RUN (new game) or SET (idle)
  typedef enum logic [2:0] {E_IDLE, E_SPIN, E_SETTLE, E_EVAL, E_HOLD} eng_t;

  localparam logic [1:0] ST_SET  = 2'b00;
  localparam logic [1:0] ST_RUN  = 2'b01;

  localparam int PW0 = (DIV0 > 1) ? $clog2(DIV0) : 1;
  localparam int PW1 = (DIV1 > 1) ? $clog2(DIV1) : 1;
  localparam int PW2 = (DIV2 > 1) ? $clog2(DIV2) : 1;
  localparam int GW  = (STOP_GAP > 1) ? $clog2(STOP_GAP) : 1;

  eng_t           eng;
  logic [PW0-1:0] pre0;
  logic [PW1-1:0] pre1;
  logic [PW2-1:0] pre2;
  logic [GW-1:0]  gap;
  logic           frz1;

  logic tick0, tick1, tick2, gap_wrap;

  assign tick0    = (pre0 == PW0'(DIV0 - 1));
  assign tick1    = (pre1 == PW1'(DIV1 - 1));
  assign tick2    = (pre2 == PW2'(DIV2 - 1));
  assign gap_wrap = (gap == GW'(STOP_GAP - 1));

  function automatic logic [SYM_W-1:0] next_sym(input logic [SYM_W-1:0] s);
    return (s == SYM_W'(NUM_SYMBOLS - 1)) ? '0 : s + 1'b1;
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      eng          <= E_IDLE;
      reel0        <= '0;
      reel1        <= '0;
      reel2        <= '0;
      pre0         <= '0;
      pre1         <= '0;
      pre2         <= '0;
      gap          <= '0;
      frz1         <= 1'b0;
      spin_active  <= 1'b0;
      result_valid <= 1'b0;
      win_flag     <= 1'b0;
      pair_flag    <= 1'b0;
    end else begin
      case (eng)
        E_IDLE, E_HOLD: begin
          if (state == ST_RUN) begin
            eng          <= E_SPIN;
            pre0         <= '0;
            pre1         <= '0;
            pre2         <= '0;
            spin_active  <= 1'b1;
            result_valid <= 1'b0;
            win_flag     <= 1'b0;
            pair_flag    <= 1'b0;
          end else if (state == ST_SET) begin
            eng          <= E_IDLE;
            result_valid <= 1'b0;
            win_flag     <= 1'b0;
            pair_flag    <= 1'b0;
          end
        end

        E_SPIN: begin
          if (state == ST_SET) begin
            eng         <= E_IDLE;
            spin_active <= 1'b0;
          end else begin
            pre1 <= tick1 ? '0 : pre1 + 1'b1;
            pre2 <= tick2 ? '0 : pre2 + 1'b1;
            if (tick1) reel1 <= next_sym(reel1);
            if (tick2) reel2 <= next_sym(reel2);
            if (state == ST_RUN) begin
              pre0 <= tick0 ? '0 : pre0 + 1'b1;
              if (tick0) reel0 <= next_sym(reel0);
            end else begin
              // STOP or WIN: reel0 freezes on this very edge
              eng  <= E_SETTLE;
              gap  <= '0;
              frz1 <= 1'b0;
            end
          end
        end

        E_SETTLE: begin
          if (state == ST_SET) begin
            eng         <= E_IDLE;
            spin_active <= 1'b0;
          end else begin
            gap <= gap_wrap ? '0 : gap + 1'b1;
            if (!frz1 && !gap_wrap) begin
              pre1 <= tick1 ? '0 : pre1 + 1'b1;
              if (tick1) reel1 <= next_sym(reel1);
            end
            if (!(frz1 && gap_wrap)) begin
              pre2 <= tick2 ? '0 : pre2 + 1'b1;
              if (tick2) reel2 <= next_sym(reel2);
            end
            if (gap_wrap) begin
              if (!frz1) begin
                frz1 <= 1'b1;
              end else begin
                eng         <= E_EVAL;
                spin_active <= 1'b0;
              end
            end
          end
        end

        E_EVAL: begin
          eng          <= E_HOLD;
          result_valid <= 1'b1;
          win_flag     <= (reel0 == reel1) && (reel1 == reel2);
          pair_flag    <= !((reel0 == reel1) && (reel1 == reel2)) &&
                          ((reel0 == reel1) || (reel1 == reel2) || (reel0 == reel2));
        end

        default: eng <= E_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_slot_reel_engine.sv
// Directed bench for slot_reel_engine: a vector table for the main game flow plus
// hand-written sequences for win/pair evaluation, restart from HOLD and async reset.
module tb_slot_reel_engine;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] state;

  logic [3:0] r0, r1, r2;
  logic       sp, rv, wf, pf;
  logic [3:0] w_r0, w_r1, w_r2;
  logic       w_sp, w_rv, w_wf, w_pf;
  logic [3:0] p_r0, p_r1, p_r2;
  logic       p_sp, p_rv, p_wf, p_pf;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  slot_reel_engine #(.NUM_SYMBOLS(4), .SYM_W(4), .DIV0(1), .DIV1(2), .DIV2(3), .STOP_GAP(2)) u_dut (
    .clk(clk), .rst(rst), .state(state),
    .reel0(r0), .reel1(r1), .reel2(r2),
    .spin_active(sp), .result_valid(rv), .win_flag(wf), .pair_flag(pf)
  );

  slot_reel_engine #(.NUM_SYMBOLS(4), .SYM_W(4), .DIV0(1), .DIV1(1), .DIV2(1), .STOP_GAP(4)) u_win (
    .clk(clk), .rst(rst), .state(state),
    .reel0(w_r0), .reel1(w_r1), .reel2(w_r2),
    .spin_active(w_sp), .result_valid(w_rv), .win_flag(w_wf), .pair_flag(w_pf)
  );

  slot_reel_engine #(.NUM_SYMBOLS(4), .SYM_W(4), .DIV0(1), .DIV1(1), .DIV2(1), .STOP_GAP(2)) u_pair (
    .clk(clk), .rst(rst), .state(state),
    .reel0(p_r0), .reel1(p_r1), .reel2(p_r2),
    .spin_active(p_sp), .result_valid(p_rv), .win_flag(p_wf), .pair_flag(p_pf)
  );

  typedef struct {
    logic [1:0] st;
    int         n;
    int         e_r0, e_r1, e_r2;
    int         e_sp, e_rv, e_wf, e_pf;
  } vec_t;

  vec_t vt [16];

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    // {state, edges, reel0, reel1, reel2, spin_active, result_valid, win, pair}
    vt[0]  = '{2'b01,  1, 0, 0, 0, 1, 0, 0, 0};  // enter SPIN
    vt[1]  = '{2'b01, 12, 0, 2, 0, 1, 0, 0, 0};  // 12 spin edges
    vt[2]  = '{2'b01,  5, 1, 0, 1, 1, 0, 0, 0};
    vt[3]  = '{2'b10,  1, 1, 1, 2, 1, 0, 0, 0};  // T0: reel0 frozen
    vt[4]  = '{2'b10,  1, 1, 1, 2, 1, 0, 0, 0};
    vt[5]  = '{2'b10,  1, 1, 1, 2, 1, 0, 0, 0};  // T0+2: reel1 frozen
    vt[6]  = '{2'b10,  1, 1, 1, 3, 1, 0, 0, 0};
    vt[7]  = '{2'b10,  1, 1, 1, 3, 0, 0, 0, 0};  // T0+4: reel2 frozen
    vt[8]  = '{2'b10,  1, 1, 1, 3, 0, 1, 0, 1};  // T0+5: result
    vt[9]  = '{2'b11,  3, 1, 1, 3, 0, 1, 0, 1};  // HOLD
    vt[10] = '{2'b00,  1, 1, 1, 3, 0, 0, 0, 0};  // back to IDLE
    vt[11] = '{2'b01,  1, 1, 1, 3, 1, 0, 0, 0};  // new game, reels keep values
    vt[12] = '{2'b01,  3, 0, 2, 0, 1, 0, 0, 0};
    vt[13] = '{2'b10,  1, 0, 3, 0, 1, 0, 0, 0};  // T0
    vt[14] = '{2'b00,  1, 0, 3, 0, 0, 0, 0, 0};  // abort at T0+1
    vt[15] = '{2'b01 ^ 2'b01, 4, 0, 3, 0, 0, 0, 0, 0};

    rst   = 1'b0;
    state = 2'b00;
    #12;
    chk("reset_reel0", int'(r0), 0);
    chk("reset_spin",  int'(sp), 0);
    chk("reset_valid", int'(rv), 0);
    rst = 1'b1;

    for (int i = 0; i < 16; i++) begin
      state = vt[i].st;
      step(vt[i].n);
      chk($sformatf("v%0d_reel0", i), int'(r0), vt[i].e_r0);
      chk($sformatf("v%0d_reel1", i), int'(r1), vt[i].e_r1);
      chk($sformatf("v%0d_reel2", i), int'(r2), vt[i].e_r2);
      chk($sformatf("v%0d_spin",  i), int'(sp), vt[i].e_sp);
      chk($sformatf("v%0d_valid", i), int'(rv), vt[i].e_rv);
      chk($sformatf("v%0d_win",   i), int'(wf), vt[i].e_wf);
      chk($sformatf("v%0d_pair",  i), int'(pf), vt[i].e_pf);
    end

    // Win / pair evaluation with equal-rate reels
    rst = 1'b0;
    #2;
    rst   = 1'b1;
    state = 2'b01;
    step(6);                       // entry + 5 spins: all reels at 1
    chk("eq_w_reel0", int'(w_r0), 1);
    chk("eq_w_reel2", int'(w_r2), 1);
    state = 2'b10;
    step(9);                       // T0 .. T0+8
    chk("win_lat_valid", int'(w_rv), 0);
    chk("pair_valid",    int'(p_rv), 1);
    chk("pair_flag",     int'(p_pf), 1);
    chk("pair_win",      int'(p_wf), 0);
    chk("pair_reel1",    int'(p_r1), 3);
    chk("pair_reel2",    int'(p_r2), 1);
    step(1);                       // T0+9
    chk("win_valid", int'(w_rv), 1);
    chk("win_flag",  int'(w_wf), 1);
    chk("win_pair",  int'(w_pf), 0);
    chk("win_reel1", int'(w_r1), 1);
    chk("win_reel2", int'(w_r2), 1);

    // Restart from HOLD clears flags on the same edge
    state = 2'b01;
    step(1);
    chk("restart_win",   int'(w_wf), 0);
    chk("restart_valid", int'(w_rv), 0);
    chk("restart_spin",  int'(w_sp), 1);
    step(2);
    chk("respin_reel0", int'(w_r0), 3);

    // Asynchronous reset mid-SPIN, checked before the next clock edge
    #3;
    rst = 1'b0;
    #1;
    chk("async_reel0", int'(w_r0), 0);
    chk("async_reel1", int'(w_r1), 0);
    chk("async_reel2", int'(w_r2), 0);
    chk("async_spin",  int'(w_sp), 0);
    chk("async_valid", int'(w_rv), 0);
    chk("async_win",   int'(w_wf), 0);
    chk("async_dut_r1", int'(r1), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
